// File: rtl/decode_instruction_queue_pkg.sv
// Shared configuration and type packages for the decode instruction queue.
// Entry layout depends on DECODE_QUEUE_ILLEGAL_PRECHECK_EN.
package taiga_config;
  localparam int unsigned DECODE_QUEUE_DEPTH = 4;
endpackage

package taiga_types;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instruction;
    logic        fetch_fault;
`ifdef DECODE_QUEUE_ILLEGAL_PRECHECK_EN
    logic        illegal;
`endif
  } decode_queue_entry_t;

  typedef enum logic [1:0] {
    Q_EMPTY,
    Q_PARTIAL,
    Q_FULL
  } queue_state_t;
endpackage

// File: rtl/decode_instruction_queue_illegal_instruction_checker.sv
// RV32I base-encoding legality check applied to fetched instruction words.
module illegal_instruction_checker (
  input  logic [31:0] instruction,
  output logic        illegal
);
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;

  assign opcode = instruction[6:0];
  assign funct3 = instruction[14:12];
  assign funct7 = instruction[31:25];

  always_comb begin
    illegal = 1'b1;
    case (opcode)
      7'b0110111, 7'b0010111, 7'b1101111, 7'b0001111: illegal = 1'b0;
      7'b1100111: illegal = (funct3 != 3'b000);
      7'b1100011: illegal = (funct3 == 3'b010) || (funct3 == 3'b011);
      7'b0000011: illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
      7'b0100011: illegal = funct3[2] || (funct3[1:0] == 2'b11);
      7'b0010011: begin
        case (funct3)
          3'b001:  illegal = (funct7 != 7'b0000000);
          3'b101:  illegal = (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
          default: illegal = 1'b0;
        endcase
      end
      7'b0110011: illegal = !((funct7 == 7'b0000000) ||
                              ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101))));
      7'b1110011: begin
        // Privileged funct3=0 group: only ECALL, EBREAK, MRET, WFI with rs1=rd=0
        if (funct3 == 3'b000)
          illegal = !((instruction[19:7] == 13'd0) &&
                      (instruction[31:20] inside {12'h000, 12'h001, 12'h302, 12'h105}));
        else
          illegal = (funct3 == 3'b100);
      end
      default: illegal = 1'b1;
    endcase
  end
endmodule

// File: rtl/decode_instruction_queue.sv
// In-order fetch-to-decode instruction queue with flush and occupancy FSM.
// Optional illegal-instruction precheck: DECODE_QUEUE_ILLEGAL_PRECHECK_EN.
module decode_instruction_queue
  import taiga_config::*;
  import taiga_types::*;
#(
  parameter int unsigned DEPTH = DECODE_QUEUE_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [31:0]              push_pc,
  input  logic [31:0]              push_instruction,
  input  logic                     push_fetch_fault,
  output logic                     full,
  input  logic                     pop,
  output logic                     valid,
  output logic [31:0]              pc,
  output logic [31:0]              instruction,
  output logic                     fetch_fault,
  output logic                     illegal,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEPTH - 1);

  queue_state_t        state, state_next;
  logic [PW-1:0]       rd_ptr, wr_ptr, rd_ptr_next, wr_ptr_next;
  logic [CW-1:0]       count_next;
  logic                push_ok, pop_ok;
  decode_queue_entry_t mem [DEPTH];
  decode_queue_entry_t entry_in, head;

`ifdef DECODE_QUEUE_ILLEGAL_PRECHECK_EN
  logic push_illegal;

  illegal_instruction_checker u_illegal_checker (
    .instruction (push_instruction),
    .illegal     (push_illegal)
  );
`endif

  always_comb begin
    entry_in             = '0;
    entry_in.pc          = push_pc;
    entry_in.instruction = push_instruction;
    entry_in.fetch_fault = push_fetch_fault;
`ifdef DECODE_QUEUE_ILLEGAL_PRECHECK_EN
    entry_in.illegal     = push_illegal;
`endif
  end

  always_comb begin
    push_ok     = push && (state != Q_FULL);
    pop_ok      = pop && (state != Q_EMPTY);
    state_next  = state;
    rd_ptr_next = rd_ptr;
    wr_ptr_next = wr_ptr;
    count_next  = count;

    if (push_ok) wr_ptr_next = wr_ptr + PTR_ONE;
    if (pop_ok)  rd_ptr_next = rd_ptr + PTR_ONE;
    if (push_ok && !pop_ok)      count_next = count + CNT_ONE;
    else if (pop_ok && !push_ok) count_next = count - CNT_ONE;

    case (state)
      Q_EMPTY:   if (push_ok) state_next = Q_PARTIAL;
      Q_PARTIAL: begin
        if (push_ok && !pop_ok && (count == CNT_LAST)) state_next = Q_FULL;
        else if (pop_ok && !push_ok && (count == CNT_ONE)) state_next = Q_EMPTY;
      end
      Q_FULL:    if (pop_ok) state_next = Q_PARTIAL;
      default:   state_next = Q_EMPTY;
    endcase

    if (flush) begin
      state_next  = Q_EMPTY;
      rd_ptr_next = '0;
      wr_ptr_next = '0;
      count_next  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= Q_EMPTY;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      state  <= state_next;
      rd_ptr <= rd_ptr_next;
      wr_ptr <= wr_ptr_next;
      count  <= count_next;
    end
  end

  // Storage is not reset; the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (rst_n && !flush && push_ok)
      mem[wr_ptr] <= entry_in;
  end

  assign valid = (state != Q_EMPTY);
  assign full  = (state == Q_FULL);
  assign head  = mem[rd_ptr];

  assign pc          = valid ? head.pc          : '0;
  assign instruction = valid ? head.instruction : '0;
  assign fetch_fault = valid ? head.fetch_fault : 1'b0;
`ifdef DECODE_QUEUE_ILLEGAL_PRECHECK_EN
  assign illegal     = valid ? head.illegal     : 1'b0;
`else
  assign illegal     = 1'b0;
`endif
endmodule

// File: tb/tb_decode_instruction_queue.sv
// Self-checking bench for decode_instruction_queue: vector table plus scoreboard.
module tb_decode_instruction_queue;
  localparam int unsigned DEPTH = 4;
`ifdef DECODE_QUEUE_ILLEGAL_PRECHECK_EN
  localparam bit ILL_EN = 1'b1;
`else
  localparam bit ILL_EN = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        push;
  logic [31:0] push_pc;
  logic [31:0] push_instruction;
  logic        push_fetch_fault;
  logic        full;
  logic        pop;
  logic        valid;
  logic [31:0] pc;
  logic [31:0] instruction;
  logic        fetch_fault;
  logic        illegal;
  logic [2:0]  count;

  decode_instruction_queue #(.DEPTH(DEPTH)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .flush            (flush),
    .push             (push),
    .push_pc          (push_pc),
    .push_instruction (push_instruction),
    .push_fetch_fault (push_fetch_fault),
    .full             (full),
    .pop              (pop),
    .valid            (valid),
    .pc               (pc),
    .instruction      (instruction),
    .fetch_fault      (fetch_fault),
    .illegal          (illegal),
    .count            (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
    logic        ff;
    logic        ill;
  } ent_t;

  typedef struct {
    logic        pu;
    logic        po;
    logic [31:0] pc;
    int          exp_count;
    logic        exp_full;
    logic        exp_valid;
    logic [31:0] exp_pc;
  } vec_t;

  typedef struct {
    logic [31:0] ins;
    logic        ill;
  } ill_vec_t;

  ent_t sbq[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b required=%b", name, act, exp);
    end
  endtask

  function automatic logic [31:0] addi_of(input logic [31:0] p);
    return {p[11:0], 5'd0, 3'b000, 5'd1, 7'h13};
  endfunction

  // One clock: drive, update scoreboard at the edge, compare outputs #1 later.
  task automatic step(input logic rn, input logic fl, input logic pu, input logic po,
                      input logic [31:0] p, input logic [31:0] ins,
                      input logic ff, input logic ill);
    ent_t e;
    bit   acc_push, acc_pop;
    rst_n            = rn;
    flush            = fl;
    push             = pu;
    pop              = po;
    push_pc          = p;
    push_instruction = ins;
    push_fetch_fault = ff;
    @(posedge clk);
    if (!rn || fl) begin
      sbq.delete();
    end else begin
      acc_pop  = po && (sbq.size() != 0);
      acc_push = pu && (sbq.size() < int'(DEPTH));
      if (acc_pop) void'(sbq.pop_front());
      if (acc_push) begin
        e.pc  = p;
        e.ins = ins;
        e.ff  = ff;
        e.ill = ILL_EN & ill;
        sbq.push_back(e);
      end
    end
    #1;
    chk32("count", 32'(count), 32'(sbq.size()));
    chk1("valid", valid, sbq.size() != 0);
    chk1("full", full, sbq.size() == int'(DEPTH));
    if (sbq.size() != 0) begin
      chk32("head_pc", pc, sbq[0].pc);
      chk32("head_instruction", instruction, sbq[0].ins);
      chk1("head_fetch_fault", fetch_fault, sbq[0].ff);
      chk1("head_illegal", illegal, sbq[0].ill);
    end else begin
      chk32("idle_pc", pc, 32'h0);
      chk32("idle_instruction", instruction, 32'h0);
      chk1("idle_fetch_fault", fetch_fault, 1'b0);
      chk1("idle_illegal", illegal, 1'b0);
    end
  endtask

  task automatic push_pc_only(input logic [31:0] p, input logic po);
    step(1'b1, 1'b0, 1'b1, po, p, addi_of(p), p[2], 1'b0);
  endtask

  task automatic idle(input logic po);
    step(1'b1, 1'b0, 1'b0, po, 32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  vec_t     tbl [9];
  ill_vec_t itbl[8];

  initial begin
    tbl[0] = '{1'b1, 1'b0, 32'h00, 1, 1'b0, 1'b1, 32'h00};
    tbl[1] = '{1'b1, 1'b0, 32'h04, 2, 1'b0, 1'b1, 32'h00};
    tbl[2] = '{1'b1, 1'b0, 32'h08, 3, 1'b0, 1'b1, 32'h00};
    tbl[3] = '{1'b1, 1'b0, 32'h0C, 4, 1'b1, 1'b1, 32'h00};
    tbl[4] = '{1'b1, 1'b0, 32'h10, 4, 1'b1, 1'b1, 32'h00};
    tbl[5] = '{1'b0, 1'b1, 32'h00, 3, 1'b0, 1'b1, 32'h04};
    tbl[6] = '{1'b0, 1'b1, 32'h00, 2, 1'b0, 1'b1, 32'h08};
    tbl[7] = '{1'b0, 1'b1, 32'h00, 1, 1'b0, 1'b1, 32'h0C};
    tbl[8] = '{1'b0, 1'b1, 32'h00, 0, 1'b0, 1'b0, 32'h00};

    itbl[0] = '{32'h00000013, 1'b0};
    itbl[1] = '{32'hFFFFFFFF, 1'b1};
    itbl[2] = '{32'h00000000, 1'b1};
    itbl[3] = '{32'h00100073, 1'b0};
    itbl[4] = '{32'h30200073, 1'b0};
    itbl[5] = '{32'h40005013, 1'b0};
    itbl[6] = '{32'h40001013, 1'b1};
    itbl[7] = '{32'h0000B003, 1'b1};

    rst_n = 1'b0; flush = 1'b0; push = 1'b0; pop = 1'b0;
    push_pc = '0; push_instruction = '0; push_fetch_fault = 1'b0;

    // Reset with a push in the same cycle: entry must be lost
    step(1'b0, 1'b0, 1'b1, 1'b0, 32'h100, addi_of(32'h100), 1'b0, 1'b0);
    chk32("reset_count", 32'(count), 32'h0);
    chk1("reset_valid", valid, 1'b0);
    chk1("reset_full", full, 1'b0);
    idle(1'b0);
    chk1("post_reset_valid", valid, 1'b0);

    // Fill, overflow push, drain
    for (int i = 0; i < 9; i++) begin
      if (tbl[i].pu) push_pc_only(tbl[i].pc, tbl[i].po);
      else           idle(tbl[i].po);
      chk32("tbl_count", 32'(count), 32'(tbl[i].exp_count));
      chk1("tbl_full", full, tbl[i].exp_full);
      chk1("tbl_valid", valid, tbl[i].exp_valid);
      chk32("tbl_pc", pc, tbl[i].exp_pc);
    end
    idle(1'b1);
    chk32("pop_empty_count", 32'(count), 32'h0);

    // Simultaneous push and pop
    push_pc_only(32'h20, 1'b0);
    push_pc_only(32'h24, 1'b0);
    push_pc_only(32'h28, 1'b1);
    chk32("simul_count", 32'(count), 32'h2);
    chk32("simul_head", pc, 32'h24);
    idle(1'b1);
    idle(1'b1);
    push_pc_only(32'h30, 1'b1);
    chk32("empty_pushpop_count", 32'(count), 32'h1);
    chk32("empty_pushpop_head", pc, 32'h30);
    idle(1'b1);

    // Flush overrides push and pop
    push_pc_only(32'h40, 1'b0);
    push_pc_only(32'h44, 1'b0);
    push_pc_only(32'h48, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1, 32'h4C, addi_of(32'h4C), 1'b0, 1'b0);
    chk32("flush_count", 32'(count), 32'h0);
    chk1("flush_valid", valid, 1'b0);
    for (int i = 0; i < 3; i++) begin
      idle(1'b0);
      chk1("post_flush_valid", valid, 1'b0);
    end

    // Pointer wrap with back-to-back push/pop
    push_pc_only(32'h50, 1'b0);
    for (int i = 0; i < 10; i++) begin
      push_pc_only(32'h54 + 32'(4 * i), 1'b1);
      chk32("wrap_count", 32'(count), 32'h1);
      chk32("wrap_head", pc, 32'h54 + 32'(4 * i));
    end
    idle(1'b1);

    // Head holds while not popped, then illegal precheck vectors
    push_pc_only(32'h60, 1'b0);
    push_pc_only(32'h64, 1'b0);
    idle(1'b0);
    idle(1'b0);
    chk32("hold_head", pc, 32'h60);
    idle(1'b1);
    idle(1'b1);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0, 1'b1, 1'b0, 32'h200 + 32'(4 * i), itbl[i].ins, 1'b0, itbl[i].ill);
      chk1("precheck_illegal", illegal, ILL_EN & itbl[i].ill);
      chk32("precheck_instruction", instruction, itbl[i].ins);
      idle(1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
